// File: rtl/cmd_reply_window_sched_if.sv
// Command-dispatch handshake bundle between the emergency controller/transmitter side
// and the reply-window scheduler.
interface cmd_reply_window_sched_if;
   logic [2:0] cmd_req;
   logic [2:0] repeat_reqs;
   logic       switch_com_src_req;
   logic       tx_frame_end;
   logic       tx_start;
   logic [2:0] tx_cmd_sel;
   logic [2:0] delays_after_cmds_for_reply;
   logic       com_src;
   logic       busy;

   modport master (
      output cmd_req, repeat_reqs, switch_com_src_req, tx_frame_end,
      input  tx_start, tx_cmd_sel, delays_after_cmds_for_reply, com_src, busy
   );

   modport slave (
      input  cmd_req, repeat_reqs, switch_com_src_req, tx_frame_end,
      output tx_start, tx_cmd_sel, delays_after_cmds_for_reply, com_src, busy
   );
endinterface

// File: rtl/cmd_reply_window_sched.sv
// Dispatch scheduler for SR/DPR/CCW: queues requests and repeats, starts the transmitter,
// then holds a one-hot reply window followed by an idle gap before the next dispatch.
module cmd_reply_window_sched #(
   parameter int REPLY_WIN_TICKS = 2000,
   parameter int GAP_TICKS       = 100,
   parameter int CNT_W           = 13
) (
   input logic                     clk,
   input logic                     n_rst,
   cmd_reply_window_sched_if.slave cmd_if
);
   typedef enum logic [2:0] {IDLE, TX_REQ, TX_WAIT, WIN, GAP} state_t;

   localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(REPLY_WIN_TICKS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       pend_q, pend_d, pend_clr;
   logic [2:0]       rpt_q, rpt_d, rpt_clr;
   logic             sw_q, sw_d, sw_clr;
   logic [2:0]       rpt_pick, pend_pick;
   logic [2:0]       sel_q, win_q;
   logic             tx_start_q, com_src_q, busy_q;

   // Isolate the lowest set bit: lowest index wins.
   assign rpt_pick  = rpt_q  & (~rpt_q  + 3'd1);
   assign pend_pick = pend_q & (~pend_q + 3'd1);

   // IDLE consumes at most one latch per cycle; new pulses always override the clear.
   always_comb begin
      pend_clr = '0;
      rpt_clr  = '0;
      sw_clr   = 1'b0;
      if (state_q == IDLE) begin
         if (sw_q) begin
            sw_clr = 1'b1;
         end else if (|rpt_q) begin
            rpt_clr  = rpt_pick;
            pend_clr = rpt_pick;
         end else begin
            pend_clr = pend_pick;
         end
      end
      pend_d = (pend_q & ~pend_clr) | cmd_if.cmd_req;
      rpt_d  = (rpt_q  & ~rpt_clr)  | cmd_if.repeat_reqs;
      sw_d   = (sw_q   & ~sw_clr)   | cmd_if.switch_com_src_req;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pend_q <= '0;
         rpt_q  <= '0;
         sw_q   <= 1'b0;
      end else begin
         pend_q <= pend_d;
         rpt_q  <= rpt_d;
         sw_q   <= sw_d;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         sel_q      <= '0;
         win_q      <= '0;
         tx_start_q <= 1'b0;
         com_src_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // A source switch is applied alone; dispatch waits one more cycle.
               if (sw_q) begin
                  com_src_q <= ~com_src_q;
               end else if ((|rpt_q) || (|pend_q)) begin
                  state_q    <= TX_REQ;
                  sel_q      <= (|rpt_q) ? rpt_pick : pend_pick;
                  tx_start_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            TX_REQ: state_q <= TX_WAIT;
            TX_WAIT: begin
               if (cmd_if.tx_frame_end) begin
                  state_q <= WIN;
                  cnt_q   <= '0;
                  win_q   <= sel_q;
               end
            end
            WIN: begin
               if (cnt_q == WIN_LAST) begin
                  state_q <= GAP;
                  cnt_q   <= '0;
                  win_q   <= '0;
                  sel_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            GAP: begin
               if (cnt_q == GAP_LAST) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_if.tx_start                    = tx_start_q;
   assign cmd_if.tx_cmd_sel                  = sel_q;
   assign cmd_if.delays_after_cmds_for_reply = win_q;
   assign cmd_if.com_src                     = com_src_q;
   assign cmd_if.busy                        = busy_q;
endmodule
